mac_vector_sequencer: RTL



---
 rtl/mac_vector_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mac_vector_sequencer.sv
// Load/run sequencer for the FP MAC datapath: captures A/B operand vectors from the keypad,
// streams element pairs to the MAC over valid/ready and holds the accumulated result.
//
// state  | meaning
// IDLE   | waiting for the first step; displays zero
// LOAD_A | each step writes key_data into A[index]
// LOAD_B | each step writes key_data into B[index]; last entry launches pair 0
// RUN    | streaming pairs to the MAC, one per handshake
// WAIT   | all pairs issued; waiting for the MAC's final accumulation
// DONE   | result held; step reruns (rerun=1) or reloads (rerun=0)
module mac_vector_sequencer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic              rerun,
    input  logic [ADDR_W:0]   vec_len,
    input  logic [DATA_W-1:0] key_data,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    output logic              mac_valid,
    output logic              mac_first,
    output logic              mac_last,
    input  logic              mac_ready,
    input  logic              acc_valid,
    input  logic [DATA_W-1:0] acc_in,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic [DATA_W-1:0] disp_data,
    output logic [2:0]        state,
    output logic [ADDR_W-1:0] index,
    output logic              step_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_RUN    = 3'd3,
        S_WAIT   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_LEN = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] IDX_ZERO  = '0;

    state_t state_q;
    state_t state_d;

    logic [DATA_W-1:0] mem_a [DEPTH];
    logic [DATA_W-1:0] mem_b [DEPTH];

    logic [ADDR_W-1:0] index_q;
    logic [ADDR_W-1:0] idx_nxt;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   len_sel;
    logic              at_last;
    logic              nxt_is_last;

    assign state   = state_q;
    assign index   = index_q;
    assign idx_nxt = index_q + IDX_ONE;

    // Zero or oversize lengths fall back to the full storage depth.
    always_comb begin
        len_sel = vec_len;
        if (vec_len == '0 || vec_len > DEPTH_LEN)
            len_sel = DEPTH_LEN;
    end

    assign at_last     = ({1'b0, index_q} == (len_q - LEN_ONE));
    assign nxt_is_last = ({1'b0, idx_nxt} == (len_q - LEN_ONE));

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (step) state_d = S_LOAD_A;
            S_LOAD_A: if (step && at_last) state_d = S_LOAD_B;
            S_LOAD_B: if (step && at_last) state_d = S_RUN;
            S_RUN:    if (mac_ready && at_last) state_d = S_WAIT;
            S_WAIT:   if (acc_valid) state_d = S_DONE;
            S_DONE:   if (step) state_d = rerun ? S_RUN : S_LOAD_A;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mac_valid = 1'b0;
        disp_data = '0;
        case (state_q)
            S_LOAD_A, S_LOAD_B: disp_data = key_data;
            S_RUN:              mac_valid = 1'b1;
            S_DONE:             disp_data = result;
            default:            ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && step && state_q == S_LOAD_A)
            mem_a[index_q] <= key_data;
        if (!rst && step && state_q == S_LOAD_B)
            mem_b[index_q] <= key_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            index_q      <= '0;
            len_q        <= DEPTH_LEN;
            mac_a        <= '0;
            mac_b        <= '0;
            mac_first    <= 1'b0;
            mac_last     <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            step_err     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (step) begin
                        len_q   <= len_sel;
                        index_q <= '0;
                    end
                end
                S_LOAD_A: begin
                    if (step)
                        index_q <= at_last ? IDX_ZERO : idx_nxt;
                end
                S_LOAD_B: begin
                    if (step) begin
                        if (at_last) begin
                            index_q   <= '0;
                            mac_a     <= mem_a[IDX_ZERO];
                            // With len 1, B[0] is being written at this very edge.
                            mac_b     <= (len_q == LEN_ONE) ? key_data : mem_b[IDX_ZERO];
                            mac_first <= 1'b1;
                            mac_last  <= (len_q == LEN_ONE);
                        end else begin
                            index_q <= idx_nxt;
                        end
                    end
                end
                S_RUN: begin
                    if (step)
                        step_err <= 1'b1;
                    if (mac_ready) begin
                        mac_first <= 1'b0;
                        if (at_last) begin
                            mac_last <= 1'b0;
                        end else begin
                            index_q  <= idx_nxt;
                            mac_a    <= mem_a[idx_nxt];
                            mac_b    <= mem_b[idx_nxt];
                            mac_last <= nxt_is_last;
                        end
                    end
                end
                S_WAIT: begin
                    if (step)
                        step_err <= 1'b1;
                    if (acc_valid) begin
                        result       <= acc_in;
                        result_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (step) begin
                        result_valid <= 1'b0;
                        step_err     <= 1'b0;
                        len_q        <= len_sel;
                        index_q      <= '0;
                        if (rerun) begin
                            mac_a     <= mem_a[IDX_ZERO];
                            mac_b     <= mem_b[IDX_ZERO];
                            mac_first <= 1'b1;
                            mac_last  <= (len_sel == LEN_ONE);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
